// File: rtl/spi_cfg_pkg.sv
// Shared types and helpers for the SPI configuration register bank.
package spi_cfg_pkg;

  typedef enum logic [1:0] {
    MODE_RW   = 2'd0,
    MODE_RO   = 2'd1,
    MODE_W1C  = 2'd2,
    MODE_RSVD = 2'd3
  } reg_mode_e;

  localparam int unsigned MODE_W   = 2;
  localparam int unsigned MAX_REGS = 256;

  // Mode field of register idx, taken from the zero-extended packed mode vector.
  function automatic reg_mode_e reg_mode(input logic [MODE_W*MAX_REGS-1:0] modes,
                                         input int unsigned idx);
    return reg_mode_e'(modes[idx*MODE_W +: MODE_W]);
  endfunction

  function automatic logic is_writable(input reg_mode_e mode);
    return (mode == MODE_RW) || (mode == MODE_W1C);
  endfunction

endpackage

// File: rtl/spi_cfg_reg_bank_if.sv
// Decoded word read/write port between the SPI protocol engine (master) and the bank (slave).
interface spi_cfg_reg_bank_if #(
  parameter int unsigned ASIZE = 15,
  parameter int unsigned DSIZE = 16
);
  logic             wr_en;
  logic [ASIZE-1:0] wr_addr;
  logic [DSIZE-1:0] wr_data;
  logic             rd_en;
  logic [ASIZE-1:0] rd_addr;
  logic             rd_vld;
  logic [DSIZE-1:0] rd_data;
  logic             rd_err;
  logic             wr_err;

  modport master (output wr_en, wr_addr, wr_data, rd_en, rd_addr,
                  input  rd_vld, rd_data, rd_err, wr_err);
  modport slave  (input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
                  output rd_vld, rd_data, rd_err, wr_err);
endinterface

// File: rtl/spi_cfg_reg_cell.sv
// One configuration register: live value, W1C status logic and update pulse.
// SPI_CFG_SHADOW_EN adds a shadow copy for RW registers, transferred to live on commit.
module spi_cfg_reg_cell
  import spi_cfg_pkg::*;
#(
  parameter int unsigned      DSIZE   = 16,
  parameter reg_mode_e        MODE    = MODE_RW,
  parameter logic [DSIZE-1:0] DEFAULT = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_hit_i,
  input  logic [DSIZE-1:0] wr_data_i,
  input  logic             commit_i,
  input  logic [DSIZE-1:0] ro_in_i,
  input  logic [DSIZE-1:0] sts_set_i,
  output logic [DSIZE-1:0] reg_out_o,
  output logic [DSIZE-1:0] rd_val_o,
  output logic             upd_pulse_o
);

  localparam bit IS_RW  = (MODE == MODE_RW);
  localparam bit IS_W1C = (MODE == MODE_W1C);
  localparam bit IS_RO  = !(IS_RW || IS_W1C);

  logic [DSIZE-1:0] live_q, live_d;
  logic             upd_q, upd_d;
`ifdef SPI_CFG_SHADOW_EN
  logic [DSIZE-1:0] shadow_q, shadow_d;
  logic             dirty_q, dirty_d;
`else
  logic unused_commit;
  assign unused_commit = commit_i;
`endif

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    live_d = live_q;
    upd_d  = 1'b0;
`ifdef SPI_CFG_SHADOW_EN
    shadow_d = shadow_q;
    dirty_d  = dirty_q;
`endif
    if (IS_W1C) begin
      // Clear is applied before set, so a coincident set wins.
      live_d = (live_q & ~(wr_hit_i ? wr_data_i : '0)) | sts_set_i;
      upd_d  = wr_hit_i;
    end else if (IS_RW) begin
`ifdef SPI_CFG_SHADOW_EN
      if (wr_hit_i) begin
        shadow_d = wr_data_i;
        dirty_d  = 1'b1;
      end
      if (commit_i) begin
        live_d  = shadow_d;
        upd_d   = dirty_q | wr_hit_i;
        dirty_d = 1'b0;
      end
`else
      if (wr_hit_i) begin
        live_d = wr_data_i;
        upd_d  = 1'b1;
      end
`endif
    end
  end

  // NOTE: state is only ever updated with non-blocking assignments.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      live_q <= DEFAULT;
      upd_q  <= 1'b0;
`ifdef SPI_CFG_SHADOW_EN
      shadow_q <= DEFAULT;
      dirty_q  <= 1'b0;
`endif
    end else begin
      live_q <= live_d;
      upd_q  <= upd_d;
`ifdef SPI_CFG_SHADOW_EN
      shadow_q <= shadow_d;
      dirty_q  <= dirty_d;
`endif
    end
  end

  assign reg_out_o   = IS_RO ? ro_in_i : live_q;
`ifdef SPI_CFG_SHADOW_EN
  assign rd_val_o    = IS_RO ? ro_in_i : (IS_RW ? shadow_q : live_q);
`else
  assign rd_val_o    = IS_RO ? ro_in_i : live_q;
`endif
  assign upd_pulse_o = upd_q;

endmodule

// File: rtl/spi_cfg_reg_bank.sv
// Addressable bank of NUM_REGS SPI configuration registers: address decode, registered read path.
// Optional shadow/commit behaviour of RW registers is enabled by SPI_CFG_SHADOW_EN.
module spi_cfg_reg_bank
  import spi_cfg_pkg::*;
#(
  parameter int unsigned ASIZE     = 15,
  parameter int unsigned DSIZE     = 16,
  parameter int unsigned NUM_REGS  = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter logic [NUM_REGS*MODE_W-1:0] REG_MODE    = '0,
  parameter logic [NUM_REGS*DSIZE-1:0]  REG_DEFAULT = '0
) (
  input  logic                      clock_i,
  input  logic                      rst_i,
  spi_cfg_reg_bank_if.slave         bus,
  input  logic                      commit_i,
  input  logic [NUM_REGS*DSIZE-1:0] ro_in_i,
  input  logic [NUM_REGS*DSIZE-1:0] sts_set_i,
  output logic [NUM_REGS*DSIZE-1:0] reg_out_o,
  output logic [NUM_REGS-1:0]       upd_pulse_o
);

  localparam int unsigned AW = ASIZE + 1;
  localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);
  localparam logic [MODE_W*MAX_REGS-1:0] MODE_ALL = (MODE_W*MAX_REGS)'(REG_MODE);

  logic [AW-1:0]    wr_idx, rd_idx;
  logic             wr_in_range, rd_in_range;
  logic [NUM_REGS-1:0] wr_hit, upd;
  logic             wr_ok;
  logic [DSIZE-1:0] rd_val [NUM_REGS];
  logic [DSIZE-1:0] rd_data_d, rd_data_q;
  logic             rd_vld_q, rd_err_q, wr_err_q;

  // Index computed one bit wider than the address so addresses below BASE wrap out of range.
  assign wr_idx      = {1'b0, bus.wr_addr} - BASE;
  assign rd_idx      = {1'b0, bus.rd_addr} - BASE;
  assign wr_in_range = ({1'b0, bus.wr_addr} >= BASE) && (wr_idx < AW'(NUM_REGS));
  assign rd_in_range = ({1'b0, bus.rd_addr} >= BASE) && (rd_idx < AW'(NUM_REGS));

  always_comb begin
    wr_hit    = '0;
    wr_ok     = 1'b0;
    rd_data_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (wr_in_range && (wr_idx == AW'(i))) begin
        wr_ok     = is_writable(reg_mode(MODE_ALL, i));
        wr_hit[i] = bus.wr_en && wr_ok;
      end
      if (rd_in_range && (rd_idx == AW'(i))) begin
        rd_data_d = rd_val[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    spi_cfg_reg_cell #(
      .DSIZE  (DSIZE),
      .MODE   (reg_mode(MODE_ALL, g)),
      .DEFAULT(REG_DEFAULT[g*DSIZE +: DSIZE])
    ) u_cell (
      .clk_i      (clock_i),
      .rst_i      (rst_i),
      .wr_hit_i   (wr_hit[g]),
      .wr_data_i  (bus.wr_data),
      .commit_i   (commit_i),
      .ro_in_i    (ro_in_i[g*DSIZE +: DSIZE]),
      .sts_set_i  (sts_set_i[g*DSIZE +: DSIZE]),
      .reg_out_o  (reg_out_o[g*DSIZE +: DSIZE]),
      .rd_val_o   (rd_val[g]),
      .upd_pulse_o(upd[g])
    );
  end

  always_ff @(posedge clock_i) begin
    if (rst_i) begin
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      rd_vld_q <= bus.rd_en;
      rd_err_q <= bus.rd_en && !rd_in_range;
      wr_err_q <= bus.wr_en && !wr_ok;
      if (bus.rd_en) rd_data_q <= rd_data_d;
    end
  end

  // Pulses are forced low while reset is held, so a read issued just before reset never reports.
  assign bus.rd_vld  = rd_vld_q & ~rst_i;
  assign bus.rd_err  = rd_err_q & ~rst_i;
  assign bus.rd_data = rd_data_q;
  assign bus.wr_err  = wr_err_q & ~rst_i;
  assign upd_pulse_o = rst_i ? '0 : upd;

endmodule

// File: tb/tb_spi_cfg_reg_bank.sv
// Scoreboard bench for spi_cfg_reg_bank; expectations follow SPI_CFG_SHADOW_EN when defined.
`timescale 1ns/1ps
module tb_spi_cfg_reg_bank;

  localparam int ASIZE = 15;
  localparam int DSIZE = 16;
  localparam int N     = 8;
  localparam int BASE  = 4;
  // reg0 RW, reg1 RW, reg2 W1C, reg3 RO, reg4 reserved, reg5..7 RW
  localparam logic [2*N-1:0]     MODES = 16'h0360;
  localparam logic [N*DSIZE-1:0] DEFS  = {16'h7777, 16'h0000, 16'hA5A5, 16'h0000,
                                          16'h0000, 16'h00F0, 16'h0011, 16'h1234};
`ifdef SPI_CFG_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  int          mode_tab [N] = '{0, 0, 2, 1, 3, 0, 0, 0};
  logic [15:0] dflt     [N] = '{16'h1234, 16'h0011, 16'h00F0, 16'h0000,
                                16'h0000, 16'hA5A5, 16'h0000, 16'h7777};

  typedef struct { logic [15:0] data; logic err; } rd_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic commit = 1'b0;
  logic [N*DSIZE-1:0] ro_in   = '0;
  logic [N*DSIZE-1:0] sts_set = '0;
  logic [N*DSIZE-1:0] reg_out;
  logic [N-1:0]       upd_pulse;

  spi_cfg_reg_bank_if #(.ASIZE(ASIZE), .DSIZE(DSIZE)) bus ();

  spi_cfg_reg_bank #(
    .ASIZE(ASIZE), .DSIZE(DSIZE), .NUM_REGS(N), .BASE_ADDR(BASE),
    .REG_MODE(MODES), .REG_DEFAULT(DEFS)
  ) dut (
    .clock_i    (clk),
    .rst_i      (rst),
    .bus        (bus),
    .commit_i   (commit),
    .ro_in_i    (ro_in),
    .sts_set_i  (sts_set),
    .reg_out_o  (reg_out),
    .upd_pulse_o(upd_pulse)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] live [N];
  logic [15:0] shadow [N];
  bit          dirty [N];
  logic [N-1:0] exp_upd = '0;
  bit          exp_wr_err = 1'b0;
  rd_exp_t     rdq [$];
  bit          mon_en = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [15:0] exp_reg_out(input int i);
    if (mode_tab[i] == 1 || mode_tab[i] == 3) return ro_in[i*DSIZE +: DSIZE];
    return live[i];
  endfunction

  function automatic logic [15:0] read_val(input int i);
    if (mode_tab[i] == 1 || mode_tab[i] == 3) return ro_in[i*DSIZE +: DSIZE];
    if (mode_tab[i] == 0 && SHADOW) return shadow[i];
    return live[i];
  endfunction

  // One clock: predict from current inputs, advance past the edge, publish expectations.
  task automatic step();
    int widx, ridx;
    bit win, rin, hit, nwerr, push;
    logic [15:0] nlive [N];
    logic [15:0] nshadow [N];
    bit ndirty [N];
    logic [N-1:0] nupd;
    logic [15:0] wd, sts, clr;
    rd_exp_t e;
    if (rst) begin
      rdq.delete();
      exp_upd    = '0;
      exp_wr_err = 1'b0;
    end
    nlive = live; nshadow = shadow; ndirty = dirty;
    nupd = '0; nwerr = 1'b0; push = 1'b0;
    e = '{data: 16'h0000, err: 1'b1};
    widx = int'(bus.wr_addr) - BASE;
    ridx = int'(bus.rd_addr) - BASE;
    win  = (widx >= 0) && (widx < N);
    rin  = (ridx >= 0) && (ridx < N);
    wd   = bus.wr_data;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        nlive[i] = dflt[i]; nshadow[i] = dflt[i]; ndirty[i] = 1'b0;
      end
    end else begin
      push = bus.rd_en;
      if (rin) e = '{data: read_val(ridx), err: 1'b0};
      nwerr = bus.wr_en && !(win && (mode_tab[widx] == 0 || mode_tab[widx] == 2));
      for (int i = 0; i < N; i++) begin
        hit = bus.wr_en && win && (widx == i);
        sts = sts_set[i*DSIZE +: DSIZE];
        if (mode_tab[i] == 2) begin
          clr      = hit ? wd : 16'h0000;
          nlive[i] = (live[i] & ~clr) | sts;
          nupd[i]  = hit;
        end else if (mode_tab[i] == 0) begin
          if (SHADOW) begin
            if (hit) begin nshadow[i] = wd; ndirty[i] = 1'b1; end
            if (commit) begin
              nlive[i]  = hit ? wd : shadow[i];
              nupd[i]   = dirty[i] || hit;
              ndirty[i] = 1'b0;
            end
          end else if (hit) begin
            nlive[i] = wd;
            nupd[i]  = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    live = nlive; shadow = nshadow; dirty = ndirty;
    exp_upd = nupd; exp_wr_err = nwerr;
    if (push) rdq.push_back(e);
    #1;
  endtask

  task automatic op(input bit we, input int wa, input logic [15:0] wd,
                    input bit re, input int ra);
    bus.wr_en   = we;
    bus.wr_addr = ASIZE'(wa);
    bus.wr_data = wd;
    bus.rd_en   = re;
    bus.rd_addr = ASIZE'(ra);
    step();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    commit = 1'b0; sts_set = '0;
  endtask

  always @(negedge clk) begin
    rd_exp_t e;
    if (mon_en) begin
      for (int i = 0; i < N; i++)
        check($sformatf("reg_out[%0d]", i), 32'(reg_out[i*DSIZE +: DSIZE]), 32'(exp_reg_out(i)));
      check("upd_pulse", 32'(upd_pulse), 32'(exp_upd));
      check("wr_err", 32'(bus.wr_err), 32'(exp_wr_err));
      if (rdq.size() != 0) begin
        e = rdq.pop_front();
        check("rd_vld", 32'(bus.rd_vld), 32'd1);
        if (bus.rd_vld) begin
          check("rd_data", 32'(bus.rd_data), 32'(e.data));
          check("rd_err", 32'(bus.rd_err), 32'(e.err));
        end
      end else begin
        check("rd_vld_idle", 32'(bus.rd_vld), 32'd0);
      end
    end
  end

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_en = 1'b0; bus.rd_addr = '0;
    for (int i = 0; i < N; i++) ro_in[i*DSIZE +: DSIZE] = 16'(32'hC000 + i);
    rst = 1'b1;
    op(0, 0, 16'h0, 0, 0);
    op(0, 0, 16'h0, 0, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset defaults, read latency
    op(0, 0, 16'h0, 1, BASE);
    op(0, 0, 16'h0, 1, BASE + 5);
    // RW write with a same-cycle read of the old value
    op(1, BASE + 1, 16'hBEEF, 1, BASE + 1);
    op(0, 0, 16'h0, 1, BASE + 1);
    // W1C: clear 0x0030 while setting 0x0010 -> set wins on bit 4
    sts_set[2*DSIZE +: DSIZE] = 16'h0010;
    op(1, BASE + 2, 16'h0030, 1, BASE + 2);
    check("w1c_value", 32'(reg_out[2*DSIZE +: DSIZE]), 32'h0000_00D0);
    // Rejected writes: RO, reserved, past the end, below the base
    op(1, BASE + 3, 16'h1111, 1, BASE + 3);
    op(1, BASE + 4, 16'h2222, 1, BASE + N);
    op(1, BASE + N, 16'h3333, 1, BASE - 1);
    op(1, BASE - 1, 16'h4444, 0, 0);
    // Shadow/commit (commit ignored without shadow)
    op(1, BASE, 16'h0055, 1, BASE);
    op(0, 0, 16'h0, 1, BASE);
    commit = 1'b1;
    op(0, 0, 16'h0, 1, BASE);
    commit = 1'b1;
    op(1, BASE + 6, 16'h6666, 1, BASE + 6);
    commit = 1'b1;
    op(0, 0, 16'h0, 1, BASE + 6);

    // Back-to-back random traffic, reset arriving mid-stream
    for (int k = 0; k < 40; k++) begin
      sts_set = {$urandom, $urandom, $urandom, $urandom};
      commit  = ($urandom_range(0, 3) == 0);
      if (k == 20) ro_in[3*DSIZE +: DSIZE] = 16'h5A5A;
      op(bit'($urandom_range(0, 1)), $urandom_range(BASE - 2, BASE + N + 1), 16'($urandom),
         1'b1, $urandom_range(BASE - 2, BASE + N + 1));
    end
    rst = 1'b1;
    op(1, BASE + 1, 16'hDEAD, 1, BASE + 1);
    rst = 1'b0;
    for (int a = BASE - 1; a <= BASE + N; a++) op(0, 0, 16'h0, 1, a);
    op(0, 0, 16'h0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
